// File: rtl/aes_pkg.sv
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared types, constants and helpers for the AES round sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_HOLD  = 3'd4
    } aes_state_t;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    // Bit r set means the key schedule advances one Nk-word iteration in round r
    localparam logic [15:0] KS_128 = 16'h03FF;
    localparam logic [15:0] KS_192 = 16'h0B75;
    localparam logic [15:0] KS_256 = 16'h2AAA;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic nr_legal(input logic [3:0] nr);
        return (nr == NR_128) || (nr == NR_192) || (nr == NR_256);
    endfunction

    function automatic logic key_step_tbl(input logic [3:0] nr, input logic [3:0] rnd);
        logic [15:0] mask;
        case (nr)
            NR_128:  mask = KS_128;
            NR_192:  mask = KS_192;
            NR_256:  mask = KS_256;
            default: mask = 16'h0000;
        endcase
        return mask[rnd];
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_rcon_gen.sv
// ============================================================================
// Module   : aes_rcon_gen
// Purpose  : Round-constant register; load forces 0x01, advance applies xtime.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_advance,
    output logic [7:0] o_rcon
);

    logic [7:0] r_rcon;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_rcon <= 8'h01;
        end else if (i_advance) begin
            r_rcon <= xtime(r_rcon);
        end
    end

    assign o_rcon = r_rcon;

endmodule

`default_nettype wire

// File: rtl/aes_round_seq.sv
// ============================================================================
// Module   : aes_round_seq
// Purpose  : One-round-per-cycle AES encryption control sequencer.
//            Optional abort input enabled by macro AES_ROUND_SEQ_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_seq
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
`ifdef AES_ROUND_SEQ_ABORT_EN
    input  logic       abort,
`endif
    input  logic       start_valid,
    output logic       start_ready,
    input  logic [3:0] Nr,
    output logic       nr_err,
    output logic       ld_text,
    output logic       sub_en,
    output logic       mix_en,
    output logic       key_step,
    output logic [7:0] rcon,
    output logic [3:0] round,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    aes_state_t r_state;
    logic [3:0] r_nr;
    logic [3:0] r_round;
    logic       r_start_ready;
    logic       r_nr_err;
    logic       r_ld_text;
    logic       r_sub_en;
    logic       r_mix_en;
    logic       r_key_step;
    logic       r_out_valid;
    logic       r_busy;

    logic       w_abort;
    logic       w_rcon_load;

`ifdef AES_ROUND_SEQ_ABORT_EN
    assign w_abort = abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // rcon sits at 0x01 throughout IDLE so the first key step of a block sees it
    assign w_rcon_load = (r_state == S_IDLE) || w_abort ||
                         ((r_state == S_HOLD) && out_ready);

    always_ff @(posedge clk) begin
        if (reset || w_abort) begin
            r_state       <= S_IDLE;
            r_round       <= 4'd0;
            r_start_ready <= 1'b1;
            r_nr_err      <= 1'b0;
            r_ld_text     <= 1'b0;
            r_sub_en      <= 1'b0;
            r_mix_en      <= 1'b0;
            r_key_step    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            if (reset) begin
                r_nr <= NR_128;
            end
        end else begin
            r_nr_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        if (nr_legal(Nr)) begin
                            r_nr          <= Nr;
                            r_state       <= S_INIT;
                            r_round       <= 4'd0;
                            r_ld_text     <= 1'b1;
                            r_key_step    <= key_step_tbl(Nr, 4'd0);
                            r_busy        <= 1'b1;
                            r_start_ready <= 1'b0;
                        end else begin
                            r_nr_err <= 1'b1;
                        end
                    end
                end
                S_INIT: begin
                    r_state    <= S_ROUND;
                    r_round    <= 4'd1;
                    r_ld_text  <= 1'b0;
                    r_sub_en   <= 1'b1;
                    r_mix_en   <= 1'b1;
                    r_key_step <= key_step_tbl(r_nr, 4'd1);
                end
                S_ROUND: begin
                    if (r_round == (r_nr - 4'd1)) begin
                        r_state    <= S_FINAL;
                        r_round    <= r_nr;
                        r_mix_en   <= 1'b0;
                        r_key_step <= key_step_tbl(r_nr, r_nr);
                    end else begin
                        r_round    <= r_round + 4'd1;
                        r_key_step <= key_step_tbl(r_nr, r_round + 4'd1);
                    end
                end
                S_FINAL: begin
                    // round index saturates at Nr while the result is held
                    r_state     <= S_HOLD;
                    r_sub_en    <= 1'b0;
                    r_mix_en    <= 1'b0;
                    r_key_step  <= 1'b0;
                    r_out_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state       <= S_IDLE;
                        r_round       <= 4'd0;
                        r_out_valid   <= 1'b0;
                        r_busy        <= 1'b0;
                        r_start_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_round       <= 4'd0;
                    r_start_ready <= 1'b1;
                    r_ld_text     <= 1'b0;
                    r_sub_en      <= 1'b0;
                    r_mix_en      <= 1'b0;
                    r_key_step    <= 1'b0;
                    r_out_valid   <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    aes_rcon_gen u_rcon_gen (
        .clk       (clk),
        .rst       (reset),
        .i_load    (w_rcon_load),
        .i_advance (r_key_step),
        .o_rcon    (rcon)
    );

    assign start_ready = r_start_ready;
    assign nr_err      = r_nr_err;
    assign ld_text     = r_ld_text;
    assign sub_en      = r_sub_en;
    assign mix_en      = r_mix_en;
    assign key_step    = r_key_step;
    assign round       = r_round;
    assign out_valid   = r_out_valid;
    assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_seq.sv
// ============================================================================
// Module   : tb_aes_round_seq
// Purpose  : Directed self-checking bench for the AES round sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_round_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_valid = 1'b0;
    logic [3:0] Nr = 4'd10;
    logic       out_ready = 1'b1;
`ifdef AES_ROUND_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       start_ready, nr_err, ld_text, sub_en, mix_en, key_step;
    logic       out_valid, busy;
    logic [7:0] rcon;
    logic [3:0] round;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    always #5 clk = ~clk;

    aes_round_seq dut (
        .clk         (clk),
        .reset       (reset),
`ifdef AES_ROUND_SEQ_ABORT_EN
        .abort       (abort),
`endif
        .start_valid (start_valid),
        .start_ready (start_ready),
        .Nr          (Nr),
        .nr_err      (nr_err),
        .ld_text     (ld_text),
        .sub_en      (sub_en),
        .mix_en      (mix_en),
        .key_step    (key_step),
        .rcon        (rcon),
        .round       (round),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {start_ready, nr_err, ld, sub, mix, ks, out_valid, busy, round, rcon}
    task automatic check_idle(input string tag);
        check(tag, {12'd0, start_ready, nr_err, ld_text, sub_en, mix_en, key_step,
                    out_valid, busy, round, rcon},
              {12'd0, 8'b1000_0000, 4'd0, 8'h01});
    endtask

    // Start one block with out_ready high and follow it cycle by cycle to IDLE
    task automatic run_block(input logic [3:0] nr, input logic [15:0] mask,
                             input int nsteps, input logic [7:0] last_rc);
        int         k;
        int         ks_seen;
        logic [7:0] rc_last;
        logic [3:0] exp_round;
        logic       exp_ld, exp_sub, exp_mix, exp_ks;
        k       = 0;
        ks_seen = 0;
        rc_last = 8'h00;
        out_ready   = 1'b1;
        Nr          = nr;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int c = 1; c <= int'(nr) + 1; c++) begin
            exp_round = 4'(c - 1);
            exp_ld    = (c == 1);
            exp_sub   = (c >= 2);
            exp_mix   = (c >= 2) && (c <= int'(nr));
            exp_ks    = mask[exp_round];
            check($sformatf("ctl_nr%0d_c%0d", nr, c),
                  {20'd0, start_ready, nr_err, out_valid, busy, ld_text, sub_en,
                   mix_en, key_step, round},
                  {20'd0, 4'b0001, exp_ld, exp_sub, exp_mix, exp_ks, exp_round});
            if (key_step) begin
                ks_seen++;
                rc_last = rcon;
            end
            if (exp_ks && k < 10) begin
                check($sformatf("rcon_nr%0d_r%0d", nr, exp_round), {24'd0, rcon},
                      {24'd0, rc_tab[k]});
                k++;
            end
            tick();
        end
        check($sformatf("ov_nr%0d", nr), {29'd0, out_valid, busy, key_step}, 32'b110);
        check($sformatf("ksn_nr%0d", nr), ks_seen, nsteps);
        check($sformatf("rclast_nr%0d", nr), {24'd0, rc_last}, {24'd0, last_rc});
        tick();
        check_idle($sformatf("idle_after_nr%0d", nr));
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check_idle("reset_vals");
        tick();
        check_idle("idle_hold");

        run_block(4'd10, 16'h03FF, 10, 8'h36);
        run_block(4'd14, 16'h2AAA, 7, 8'h40);
        run_block(4'd12, 16'h0B75, 8, 8'h80);

        // Illegal Nr: handshake accepted, error pulse, no block started
        Nr          = 4'd11;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        check("nrerr_pulse", {29'd0, nr_err, busy, start_ready}, 32'b101);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("nrerr_after%0d", i), {29'd0, nr_err, busy, out_valid}, 32'b000);
        end

        // Back-pressure in HOLD with a stray start request
        Nr          = 4'd10;
        out_ready   = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int c = 1; c < 12; c++) tick();
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1;
            check($sformatf("hold_%0d", i),
                  {25'd0, start_ready, out_valid, busy, ld_text, sub_en, mix_en, key_step},
                  {25'd0, 7'b0110000});
            tick();
        end
        start_valid = 1'b0;
        check("hold_last", {30'd0, out_valid, busy}, 32'b11);
        out_ready = 1'b1;
        tick();
        check_idle("hold_release");
        tick();
        check_idle("no_queued_start");

        // Reset in the middle of round 5
        Nr          = 4'd10;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        check("mid_round5", {28'd0, round}, 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("reset_mid");
        run_block(4'd10, 16'h03FF, 10, 8'h36);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_round_seq.md
AES_ROUND_SEQ -- requirements
Module: aes_round_seq

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Port `clk`, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-003 Port `reset`, input, 1 bit: synchronous, active-high.
REQ-004 Port `start_valid`, input, 1 bit: request to encrypt one block.
REQ-005 Port `start_ready`, output, 1 bit: high only in IDLE.
REQ-006 Port `Nr`, input, 4 bits: round count, sampled at start handshake; legal values 10, 12, 14.
REQ-007 Port `nr_err`, output, 1 bit: one-cycle pulse when an illegal Nr is accepted.
REQ-008 Port `ld_text`, output, 1 bit: datapath state register loads the input text; round-0 AddRoundKey only.
REQ-009 Port `sub_en`, output, 1 bit: enables SubBytes/ShiftRows for this cycle's round.
REQ-010 Port `mix_en`, output, 1 bit: enables MixColumns for this cycle's round.
REQ-011 Port `key_step`, output, 1 bit: key expansion performs one Nk-word iteration this cycle.
REQ-012 Port `rcon`, output, 8 bits: round constant, meaningful while `key_step`=1.
REQ-013 Port `round`, output, 4 bits: current round index.
REQ-014 Port `out_valid`, output, 1 bit: Cipher register holds the result.
REQ-015 Port `out_ready`, input, 1 bit: consumer accepts the result.
REQ-016 Port `busy`, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 States: IDLE, INIT, ROUND, FINAL, HOLD; one AES round per cycle.
REQ-018 IDLE->INIT on `start_valid`&`start_ready` with legal Nr; Nr latched internally.
REQ-019 Illegal Nr at the handshake: the handshake completes, `nr_err`=1 the next cycle, and the state stays IDLE.
REQ-020 INIT (one cycle): `round`=0, `ld_text`=1, `sub_en`=0, `mix_en`=0.
REQ-021 ROUND: `round`=1..Nr-1 incrementing each cycle, `sub_en`=1, `mix_en`=1; ROUND->FINAL after round Nr-1.
REQ-022 FINAL (one cycle): `round`=Nr, `sub_en`=1, `mix_en`=0; FINAL->HOLD.
REQ-023 HOLD: `out_valid`=1 until `out_valid`&`out_ready`; then HOLD->IDLE on that edge.
REQ-024 Latency: `out_valid` first high exactly Nr+2 cycles after the start handshake edge.
REQ-025 `start_valid` outside IDLE is ignored and not queued.
REQ-026 `key_step` is asserted in these rounds:
- Nr=10: rounds 0-9.
- Nr=12: rounds 0, 2, 4, 5, 6, 8, 9, 11.
- Nr=14: rounds 1, 3, 5, 7, 9, 11, 13.
- `key_step`=0 in all other rounds and in IDLE/HOLD.
REQ-027 `rcon` is 0x01 at the first `key_step` of a block and advances by GF(2^8) xtime after each `key_step` (0x80->0x1B); last values are 0x36 (Nr=10), 0x80 (Nr=12), 0x40 (Nr=14).
REQ-028 `round` wraps never; the counter saturates at Nr.
REQ-029 All control outputs are 0 in IDLE and HOLD, except `out_valid` and `busy` in HOLD.

Reset
REQ-030 Reset has priority over every input, including mid-round and in HOLD.
REQ-031 Next state after reset is IDLE.
REQ-032 Reset values:
- `start_ready`=1.
- `rcon`=0x01.
- `round`=0.
- All other outputs 0.
REQ-033 A block in flight at reset is discarded with no `out_valid`.

Configuration
REQ-034 Macro AES_ROUND_SEQ_ABORT_EN defined: the block SHALL add input `abort` (1 bit); `abort`=1 in INIT/ROUND/FINAL/HOLD forces IDLE next cycle with the REQ-032 output values.
REQ-035 `abort` in IDLE is ignored; `reset` dominates `abort`.
REQ-036 Macro AES_ROUND_SEQ_ABORT_EN undefined: the `abort` port SHALL be absent and the behaviour unchanged otherwise.

Structure
REQ-037 Shared package `aes_pkg` SHALL hold: the state enum, the NR_128/NR_192/NR_256 constants (10/12/14), the xtime function, and the key_step round tables.
REQ-038 One sub-module, `aes_rcon_gen`, SHALL hold the rcon register with load-0x01/advance controls; all other logic stays in `aes_round_seq`.

Verification
REQ-039 Nr=10, start at cycle 0, `out_ready`=1: `round` sequence 0..10; `mix_en`=0 in rounds 0 and 10; `out_valid` at cycle 12; `rcon` over the 10 steps: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
REQ-040 Nr=14: `key_step` exactly in rounds 1, 3, ..., 13; final `rcon`=0x40; `out_valid` at cycle 16.
REQ-041 Nr=12: 8 key steps in rounds 0, 2, 4, 5, 6, 8, 9, 11; final `rcon`=0x80; `out_valid` at cycle 14.
REQ-042 Nr=11: `nr_err` pulses one cycle, `busy` stays 0, no `out_valid`.
REQ-043 `out_ready` held low 5 cycles in HOLD: `out_valid` stays 1; a `start_valid` during HOLD is ignored; return to IDLE one edge after `out_ready`=1.
REQ-044 Reset asserted at round 5 of Nr=10: next cycle IDLE, all outputs at reset values; a new start then completes normally in 12 cycles.
